// File: rtl/inv_affine_serial.sv
// Row-serial inverse affine transform: out = W_INV * (in ^ w) over GF(2),
// evaluating ROWS_PER_CYCLE matrix rows per clock behind valid/ready handshakes.
module inv_affine_serial #(
  parameter int                  d              = 4,
  parameter logic [0:7+d][0:7+d] W_INV          = {{(7+d){1'b1, {(8+d){1'b0}}}}, 1'b1},
  parameter logic [0:7+d]        w              = '0,
  parameter int                  ROWS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:7+d] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:7+d] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int N     = 8 + d;
  localparam int ROW_W = $clog2(N);
  localparam logic [ROW_W-1:0] ROW_STEP = ROW_W'(ROWS_PER_CYCLE);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N - ROWS_PER_CYCLE);

  generate
    if (ROWS_PER_CYCLE < 1 || (N % ROWS_PER_CYCLE) != 0) begin : g_bad_rows
      $error("inv_affine_serial: ROWS_PER_CYCLE must divide the symbol width");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    state, state_nxt;
  logic [0:N-1]              x;
  logic [ROW_W-1:0]          row;
  logic [0:ROWS_PER_CYCLE-1] grp;
  logic                      last_grp;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign last_grp  = (row == ROW_LAST);

  // Only the current group of rows is evaluated; the rest of the matrix is idle.
  always_comb begin
    grp = '0;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      grp[j] = ^(W_INV[row + ROW_W'(j)] & x);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_grp)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row      <= '0;
      x        <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        x        <= in_data ^ w;
        row      <= '0;
        out_data <= '0;
      end
      // out_data fills in one row group per cycle; it is only meaningful in DONE.
      if (state == BUSY) begin
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
          out_data[row + ROW_W'(j)] <= grp[j];
        end
        row <= last_grp ? '0 : row + ROW_STEP;
      end
    end
  end

endmodule

// File: tb/tb_inv_affine_serial.sv
// Bench for inv_affine_serial: three configurations checked against a GF(2)
// matrix model, including a round trip through the forward transform.
module tb_inv_affine_serial;

  localparam logic [0:11][0:11] WI2 = {
    12'b1011_0010_1101, 12'b0110_1001_0110, 12'b0011_0110_1001, 12'b0001_1100_0111,
    12'b0000_1011_0100, 12'b0000_0110_1011, 12'b0000_0011_0010, 12'b0000_0001_1101,
    12'b0000_0000_1011, 12'b0000_0000_0110, 12'b0000_0000_0011, 12'b0000_0000_0001};
  localparam logic [0:11][0:11] ID12 = {{11{1'b1, {12{1'b0}}}}, 1'b1};
  localparam logic [0:11] W0 = 12'h000;
  localparam logic [0:11] W1 = 12'hFFF;
  localparam logic [0:11] W2 = 12'h5A3;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic [0:11] in_data   [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [0:11] out_data  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        busy      [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inv_affine_serial u_dut0 (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .busy(busy[0]));

  inv_affine_serial #(.d(4), .W_INV(ID12), .w(W1), .ROWS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .busy(busy[1]));

  inv_affine_serial #(.d(4), .W_INV(WI2), .w(W2), .ROWS_PER_CYCLE(4)) u_dut2 (
    .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:11] matvec(input logic [0:11][0:11] m, input logic [0:11] v);
    logic [0:11] r;
    for (int i = 0; i < 12; i++) r[i] = ^(m[i] & v);
    return r;
  endfunction

  // Gauss-Jordan inversion over GF(2); used to build the forward matrix W.
  function automatic logic [0:11][0:11] gf2_inv(input logic [0:11][0:11] m);
    logic [0:11][0:11] a, b;
    logic [0:11]       t;
    a = m;
    b = ID12;
    for (int c = 0; c < 12; c++) begin
      for (int p = c; p < 12; p++) begin
        if (a[p][c]) begin
          t = a[p]; a[p] = a[c]; a[c] = t;
          t = b[p]; b[p] = b[c]; b[c] = t;
          break;
        end
      end
      for (int r = 0; r < 12; r++) begin
        if (r != c && a[r][c]) begin
          a[r] = a[r] ^ a[c];
          b[r] = b[r] ^ b[c];
        end
      end
    end
    return b;
  endfunction

  // One full transaction with out_ready held high; called #1 after a clock edge.
  task automatic run_op(input int k, input logic [0:11] din, input logic [0:11] exp,
                        input int lat, input string tag);
    int n;
    check({tag, "_in_ready"}, 12'(in_ready[k]), 12'd1);
    in_data[k]   = din;
    in_valid[k]  = 1'b1;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    in_data[k]  = 12'(~din);
    n = 0;
    while (!out_valid[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 12'(n), 12'(lat));
    check({tag, "_data"}, out_data[k], exp);
    @(posedge clk); #1;
    check({tag, "_drain_valid"}, 12'(out_valid[k]), 12'd0);
    check({tag, "_drain_ready"}, 12'(in_ready[k]), 12'd1);
  endtask

  initial begin
    logic [0:11][0:11] wf;
    logic [0:11]       v, y, exp_v;
    int                n;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; in_data[k] = '0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", 12'(out_valid[k]), 12'd0);
      check("rst_out_data",  out_data[k], 12'h000);
      check("rst_busy",      12'(busy[k]), 12'd0);
      check("rst_in_ready",  12'(in_ready[k]), 12'd1);
    end

    run_op(0, 12'hA5C, 12'hA5C, 12, "id_a5c");
    run_op(1, 12'h0F3, 12'hF0C, 12, "wfff_0f3");
    for (int i = 0; i < 8; i++) begin
      v = 12'($urandom);
      run_op(0, v, matvec(ID12, v ^ W0), 12, "id_rand");
      v = 12'($urandom);
      run_op(1, v, matvec(ID12, v ^ W1), 12, "wfff_rand");
    end

    // Backpressure: hold the result, ignore in_valid pulses while DONE.
    v = 12'($urandom);
    in_data[0] = v; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_latency", 12'(n), 12'd12);
    for (int i = 0; i < 7; i++) begin
      check("bp_valid", 12'(out_valid[0]), 12'd1);
      check("bp_data",  out_data[0], v);
      check("bp_in_ready", 12'(in_ready[0]), 12'd0);
      in_data[0]  = 12'($urandom);
      in_valid[0] = i[0];
      @(posedge clk); #1;
    end
    check("bp_hold_valid", 12'(out_valid[0]), 12'd1);
    check("bp_hold_data",  out_data[0], v);
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_drain_valid", 12'(out_valid[0]), 12'd0);
    check("bp_drain_ready", 12'(in_ready[0]), 12'd1);
    check("bp_keep_data",   out_data[0], v);

    // Reset during BUSY.
    in_data[0] = 12'h5A5; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 12'(busy[0]), 12'd1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check("mid_rst_valid", 12'(out_valid[0]), 12'd0);
    check("mid_rst_data",  out_data[0], 12'h000);
    check("mid_rst_busy",  12'(busy[0]), 12'd0);
    check("mid_rst_ready", 12'(in_ready[0]), 12'd1);
    run_op(0, 12'h123, 12'h123, 12, "post_rst");

    // Round trip through the forward transform, back-to-back every 5 cycles.
    wf = gf2_inv(WI2);
    for (int i = 0; i < 200; i++) begin
      v = 12'($urandom);
      y = matvec(wf, v) ^ W2;
      exp_v = v;
      run_op(2, y, exp_v, 3, "rt");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inv_affine_serial.md
Name: inv_affine_serial

Overview:
Computes the inverse of the S-box affine transform on a redundant (8+d)-bit symbol: out = W_INV · (in ⊕ w) over GF(2).
- Unlike the combinational forward transform, it evaluates ROWS_PER_CYCLE matrix rows per clock. This trades latency for area in the decode/check path of the protected S-box.
- Valid/ready handshake on both sides.
- Output registered and held until consumed.

Parameters:
d, 4, number of redundancy bits; symbol width N = 8+d.
W_INV, identity [0:7+d][0:7+d], GF(2) inverse matrix; row i produces output bit i. Index 0 is the MSB and the leftmost bit.
w, '0 [0:7+d], additive vector of the forward transform; XORed into the input before multiplication.
ROWS_PER_CYCLE, 1, rows evaluated per clock; must divide N (elaboration error otherwise).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_data  input  [0:7+d]  symbol to invert
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a symbol
out_data  output  [0:7+d]  result W_INV·(in_data⊕w)
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
busy  output  1  high while in BUSY state

Behaviour:
- Let C = N/ROWS_PER_CYCLE.
- FSM states are IDLE, BUSY and DONE.
- Reset values: state=IDLE, out_data='0, out_valid=0, busy=0, row counter=0, operand register='0. in_ready=1 in the first cycle after reset.
- in_ready = (state==IDLE); combinational from state only, never from in_valid.
- Accept: on an edge with in_valid && in_ready:
  - operand register x <= in_data ^ w
  - row counter <= 0, out_data <= '0
  - state <= BUSY
- BUSY, each edge, for j in 0..ROWS_PER_CYCLE-1:
  - r = row+j
  - out_data[r] <= XOR-reduce(W_INV[r] & x)
  - row <= row + ROWS_PER_CYCLE
- Leaving BUSY: on the edge that computes row N-ROWS_PER_CYCLE (the last group), state <= DONE and out_valid <= 1. The row counter wraps to 0.
- Latency: accept at edge k gives out_valid high after edge k+C. With defaults that is 12 cycles; ROWS_PER_CYCLE=4 gives 3.
- During BUSY:
  - out_data is partially written but out_valid=0; consumers must ignore it.
  - x is constant.
  - in_valid is ignored.
- DONE:
  - out_data and out_valid are held stable for any number of cycles while out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, state <= IDLE. out_data keeps its value until the next accept.
- Throughput: one symbol per C+2 cycles minimum (accept, C compute, drain). No overlap of accept and drain, because in_ready=0 in DONE.
- out_ready while out_valid=0 has no effect.
- rst during any state:
  - returns to reset values on that edge
  - discards the in-flight result
  - never produces a pulse of out_valid
- rst takes priority over accept and drain on the same edge.
- Arithmetic is pure GF(2): AND then XOR-reduce per row. No carries, no width growth.
- Round-trip property: for an invertible W with W_INV = W⁻¹, feeding y = W·x ^ w returns x.

Test Plan:
- Defaults (d=4, identity, w=0): in_data=12'hA5C, in_valid pulse, out_ready=1 → out_valid rises 12 cycles after accept, out_data=12'hA5C, in_ready high the cycle after drain.
- Identity, w=12'hFFF: in_data=12'h0F3 → out_data=12'hF0C.
- Backpressure: out_ready=0 for 7 cycles after out_valid → out_data/out_valid stable, in_ready=0 throughout, in_valid pulses ignored. Drain on out_ready=1 gives in_ready=1 next cycle.
- Reset mid-op: assert rst at the 5th BUSY cycle → next cycle out_valid=0, out_data=0, busy=0, in_ready=1; a new symbol 12'h123 (identity, w=0) then completes with out_data=12'h123.
- ROWS_PER_CYCLE=4, random invertible W/W_INV pair, w=12'h5A3: 200 random x through a forward model y=W·x^w → out_data==x each time, latency exactly 3, back-to-back accepts every 5 cycles with out_ready=1.
- Illegal ROWS_PER_CYCLE=5 with d=4 → elaboration fails.
